tnoc_vc_credit_arbiter: RTL and testbench

- Shares one physical flit link between CHANNELS virtual channels (VCs).
- Per flit, picks one eligible VC round-robin. A VC is eligible only if it holds a downstream credit.
- Tracks per-VC downstream buffer credits and registers the winning flit onto the link.
- Sits at a router output port, in front of the link to the neighbouring router's input VC buffers.

---
 rtl/tnoc_vc_credit_arbiter.sv | 166 ++++++++++++++++
 tb/tb_tnoc_vc_credit_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tnoc_vc_credit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tnoc_vc_credit_arbiter
// Brief    : Credit-gated round-robin arbiter sharing one registered flit link
//            between CHANNELS virtual channels.
// Revision : 1.0 - initial release
// ============================================================================
module tnoc_vc_credit_arbiter #(
   parameter int CHANNELS     = 2,
   parameter int FLIT_WIDTH   = 64,
   parameter int CREDITS      = 4,
   parameter int CREDIT_WIDTH = $clog2(CREDITS + 1)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [CHANNELS-1:0]            i_valid,
   input  logic [CHANNELS*FLIT_WIDTH-1:0] i_flit,
   output logic [CHANNELS-1:0]            o_ready,
   output logic                           o_valid,
   output logic [FLIT_WIDTH-1:0]          o_flit,
   output logic [CHANNELS-1:0]            o_vc,
   input  logic [CHANNELS-1:0]            i_credit_return,
   output logic [CHANNELS-1:0]            o_credit_available,
   output logic                           o_credit_error
);

   localparam int                      c_ptr_width  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [CREDIT_WIDTH-1:0] c_credit_max = CREDIT_WIDTH'(CREDITS);

   logic [CREDIT_WIDTH-1:0] r_credit [CHANNELS];
   logic [c_ptr_width-1:0]  r_rr_ptr;
   logic                    r_valid;
   logic [FLIT_WIDTH-1:0]   r_flit;
   logic [CHANNELS-1:0]     r_vc;
   logic                    r_credit_error;

   logic [CHANNELS-1:0]     w_elig;
   logic [CHANNELS-1:0]     w_grant;
   logic [CHANNELS-1:0]     w_credit_over;
   logic                    w_grant_any;
   logic [c_ptr_width-1:0]  w_grant_idx;
   logic [FLIT_WIDTH-1:0]   w_grant_flit;
   int                      w_scan_idx;

   // A VC may only compete while it still owns a downstream buffer slot.
   generate
      for (genvar k = 0; k < CHANNELS; k++) begin : g_elig
         assign o_credit_available[k] = (r_credit[k] != '0);
         assign w_elig[k]             = i_valid[k] && (r_credit[k] != '0);
      end
   endgenerate

   always_comb begin
      w_grant_any = 1'b0;
      w_grant_idx = '0;
      w_scan_idx  = 0;
      for (int i = 0; i < CHANNELS; i++) begin
         w_scan_idx = int'(r_rr_ptr) + i;
         if (w_scan_idx >= CHANNELS) begin
            w_scan_idx = w_scan_idx - CHANNELS;
         end
         if (!w_grant_any && w_elig[w_scan_idx]) begin
            w_grant_any = 1'b1;
            w_grant_idx = c_ptr_width'(w_scan_idx);
         end
      end
   end

   // Grants are suppressed while reset is held so no credit is consumed.
   always_comb begin
      w_grant = '0;
      if (w_grant_any && !rst) begin
         w_grant = CHANNELS'(1) << w_grant_idx;
      end
   end

   assign o_ready = w_grant;

   always_comb begin
      w_grant_flit = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (w_grant[k]) begin
            w_grant_flit = i_flit[k*FLIT_WIDTH +: FLIT_WIDTH];
         end
      end
   end

   generate
      if (CHANNELS > 1) begin : g_rr_ptr
         logic [c_ptr_width-1:0] w_next_ptr;

         always_comb begin
            if (int'(w_grant_idx) == CHANNELS - 1) begin
               w_next_ptr = '0;
            end else begin
               w_next_ptr = w_grant_idx + c_ptr_width'(1);
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_rr_ptr <= '0;
            end else if (w_grant_any) begin
               r_rr_ptr <= w_next_ptr;
            end
         end
      end else begin : g_single
         assign r_rr_ptr = '0;
      end
   endgenerate

   // Simultaneous grant and return cancel; an over-return saturates and flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < CHANNELS; k++) begin
            r_credit[k] <= c_credit_max;
         end
      end else begin
         for (int k = 0; k < CHANNELS; k++) begin
            if (w_grant[k] && !i_credit_return[k]) begin
               r_credit[k] <= r_credit[k] - CREDIT_WIDTH'(1);
            end else if (i_credit_return[k] && !w_grant[k] &&
                         (r_credit[k] != c_credit_max)) begin
               r_credit[k] <= r_credit[k] + CREDIT_WIDTH'(1);
            end
         end
      end
   end

   generate
      for (genvar k = 0; k < CHANNELS; k++) begin : g_over
         assign w_credit_over[k] = i_credit_return[k] && !w_grant[k] &&
                                   (r_credit[k] == c_credit_max);
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_credit_error <= 1'b0;
      end else if (|w_credit_over) begin
         r_credit_error <= 1'b1;
      end
   end

   // Link register: flit and tag hold when idle, only valid pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_flit  <= '0;
         r_vc    <= '0;
      end else begin
         r_valid <= w_grant_any;
         if (w_grant_any) begin
            r_flit <= w_grant_flit;
            r_vc   <= w_grant;
         end
      end
   end

   assign o_valid        = r_valid;
   assign o_flit         = r_flit;
   assign o_vc           = r_vc;
   assign o_credit_error = r_credit_error;

endmodule
`default_nettype wire

// File: tb/tb_tnoc_vc_credit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tnoc_vc_credit_arbiter
// Brief    : Directed self-checking bench for tnoc_vc_credit_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tnoc_vc_credit_arbiter;

   localparam int CH = 2;
   localparam int FW = 64;
   localparam int CR = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [CH-1:0]     i_valid;
   logic [CH*FW-1:0]  i_flit;
   logic [CH-1:0]     o_ready;
   logic              o_valid;
   logic [FW-1:0]     o_flit;
   logic [CH-1:0]     o_vc;
   logic [CH-1:0]     i_credit_return;
   logic [CH-1:0]     o_credit_available;
   logic              o_credit_error;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   tnoc_vc_credit_arbiter #(
      .CHANNELS   (CH),
      .FLIT_WIDTH (FW),
      .CREDITS    (CR)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .i_valid            (i_valid),
      .i_flit             (i_flit),
      .o_ready            (o_ready),
      .o_valid            (o_valid),
      .o_flit             (o_flit),
      .o_vc               (o_vc),
      .i_credit_return    (i_credit_return),
      .o_credit_available (o_credit_available),
      .o_credit_error     (o_credit_error)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst             = 1'b1;
      i_valid         = '0;
      i_credit_return = '0;
      i_flit          = '0;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst             = 1'b1;
      i_valid         = 2'b11;
      i_credit_return = '0;
      i_flit          = '0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++;
         if (o_ready !== 2'b00) begin
            bad++; $display("FAIL reset_ready_in_rst: got %b expected 00", o_ready);
         end
         total++;
         if (o_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid_in_rst: got %b expected 0", o_valid);
         end
         tick();
      end
      rst     = 1'b0;
      i_valid = 2'b00;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         total++;
         if (o_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid: got %b expected 0", o_valid);
         end
         total++;
         if (o_credit_available !== 2'b11) begin
            bad++; $display("FAIL reset_avail: got %b expected 11", o_credit_available);
         end
         total++;
         if (o_credit_error !== 1'b0) begin
            bad++; $display("FAIL reset_err: got %b expected 0", o_credit_error);
         end
         total++;
         if (o_ready !== 2'b00) begin
            bad++; $display("FAIL reset_ready: got %b expected 00", o_ready);
         end
         total++;
         if (o_flit !== 64'h0 || o_vc !== 2'b00) begin
            bad++; $display("FAIL reset_flit: got %h/%b expected 0/00", o_flit, o_vc);
         end
         tick();
      end
   endtask

   task automatic test_single_burst();
      logic [CH-1:0] exp_ready;
      logic [CH-1:0] exp_avail;
      for (int c = 0; c <= 6; c++) begin
         tick();
         i_valid          = (c < 6) ? 2'b01 : 2'b00;
         i_flit[0 +: FW]  = 64'h10 + 64'(c);
         @(negedge clk);
         exp_ready = (c < 4) ? 2'b01 : 2'b00;
         exp_avail = (c < 4) ? 2'b11 : 2'b10;
         total++;
         if (o_ready !== exp_ready) begin
            bad++; $display("FAIL burst_ready c=%0d: got %b expected %b", c, o_ready, exp_ready);
         end
         total++;
         if (o_credit_available !== exp_avail) begin
            bad++; $display("FAIL burst_avail c=%0d: got %b expected %b", c, o_credit_available, exp_avail);
         end
         if (c >= 1 && c <= 4) begin
            total++;
            if (o_valid !== 1'b1 || o_flit !== 64'h10 + 64'(c - 1) || o_vc !== 2'b01) begin
               bad++; $display("FAIL burst_link c=%0d: got %b/%h/%b expected 1/%h/01",
                               c, o_valid, o_flit, o_vc, 64'h10 + 64'(c - 1));
            end
         end else if (c >= 5) begin
            total++;
            if (o_valid !== 1'b0 || o_flit !== 64'h13 || o_vc !== 2'b01) begin
               bad++; $display("FAIL burst_hold c=%0d: got %b/%h/%b expected 0/13/01",
                               c, o_valid, o_flit, o_vc);
            end
         end else begin
            total++;
            if (o_valid !== 1'b0) begin
               bad++; $display("FAIL burst_first c=%0d: got %b expected 0", c, o_valid);
            end
         end
      end
   endtask

   task automatic test_starved_recovery();
      tick();
      i_valid         = 2'b01;
      i_credit_return = 2'b01;
      @(negedge clk);
      total++;
      if (o_ready !== 2'b00) begin
         bad++; $display("FAIL starve_n_ready: got %b expected 00", o_ready);
      end
      tick();
      i_credit_return = 2'b00;
      i_flit[0 +: FW] = 64'h77;
      @(negedge clk);
      total++;
      if (o_ready !== 2'b01) begin
         bad++; $display("FAIL starve_n1_ready: got %b expected 01", o_ready);
      end
      total++;
      if (o_credit_available !== 2'b11) begin
         bad++; $display("FAIL starve_n1_avail: got %b expected 11", o_credit_available);
      end
      tick();
      i_valid = 2'b00;
      @(negedge clk);
      total++;
      if (o_valid !== 1'b1 || o_vc !== 2'b01 || o_flit !== 64'h77) begin
         bad++; $display("FAIL starve_n2_link: got %b/%b/%h expected 1/01/77", o_valid, o_vc, o_flit);
      end
      total++;
      if (o_credit_available !== 2'b10) begin
         bad++; $display("FAIL starve_n2_avail: got %b expected 10", o_credit_available);
      end
   endtask

   task automatic test_round_robin();
      logic [CH-1:0] sched [16];
      logic [CH-1:0] exp_ready;
      logic [CH-1:0] exp_vc;
      logic [FW-1:0] exp_flit;
      for (int i = 0; i < 16; i++) sched[i] = '0;
      apply_reset();
      for (int c = 0; c < 12; c++) begin
         tick();
         i_valid          = 2'b11;
         i_flit[0 +: FW]  = 64'hA000 + 64'(c);
         i_flit[FW +: FW] = 64'hB000 + 64'(c);
         i_credit_return  = sched[c];
         @(negedge clk);
         exp_ready = (c % 2 == 0) ? 2'b01 : 2'b10;
         total++;
         if (o_ready !== exp_ready) begin
            bad++; $display("FAIL rr_ready c=%0d: got %b expected %b", c, o_ready, exp_ready);
         end
         if (c >= 1) begin
            exp_vc   = ((c - 1) % 2 == 0) ? 2'b01 : 2'b10;
            exp_flit = ((c - 1) % 2 == 0) ? 64'hA000 + 64'(c - 1) : 64'hB000 + 64'(c - 1);
            total++;
            if (o_valid !== 1'b1 || o_vc !== exp_vc || o_flit !== exp_flit) begin
               bad++; $display("FAIL rr_link c=%0d: got %b/%b/%h expected 1/%b/%h",
                               c, o_valid, o_vc, o_flit, exp_vc, exp_flit);
            end
         end
         sched[c + 2] = o_valid ? o_vc : 2'b00;
      end
   endtask

   task automatic test_simultaneous();
      logic [CH-1:0] exp_ready;
      apply_reset();
      for (int c = 0; c < 6; c++) begin
         tick();
         i_valid         = 2'b10;
         i_credit_return = (c == 2) ? 2'b10 : 2'b00;
         @(negedge clk);
         exp_ready = (c < 5) ? 2'b10 : 2'b00;
         total++;
         if (o_ready !== exp_ready) begin
            bad++; $display("FAIL simul_ready c=%0d: got %b expected %b", c, o_ready, exp_ready);
         end
      end
      total++;
      if (o_credit_available !== 2'b01) begin
         bad++; $display("FAIL simul_avail: got %b expected 01", o_credit_available);
      end
      total++;
      if (o_credit_error !== 1'b0) begin
         bad++; $display("FAIL simul_err: got %b expected 0", o_credit_error);
      end
   endtask

   task automatic test_over_return();
      logic [CH-1:0] exp_ready;
      apply_reset();
      tick();
      i_valid         = 2'b00;
      i_credit_return = 2'b10;
      @(negedge clk);
      total++;
      if (o_credit_error !== 1'b0) begin
         bad++; $display("FAIL over_err_same: got %b expected 0", o_credit_error);
      end
      tick();
      i_credit_return = 2'b00;
      @(negedge clk);
      total++;
      if (o_credit_error !== 1'b1) begin
         bad++; $display("FAIL over_err_next: got %b expected 1", o_credit_error);
      end
      total++;
      if (o_credit_available !== 2'b11) begin
         bad++; $display("FAIL over_avail: got %b expected 11", o_credit_available);
      end
      for (int c = 0; c < 5; c++) begin
         tick();
         i_valid          = 2'b10;
         i_flit[FW +: FW] = 64'hC0 + 64'(c);
         @(negedge clk);
         exp_ready = (c < 4) ? 2'b10 : 2'b00;
         total++;
         if (o_ready !== exp_ready) begin
            bad++; $display("FAIL over_ready c=%0d: got %b expected %b", c, o_ready, exp_ready);
         end
         total++;
         if (o_credit_error !== 1'b1) begin
            bad++; $display("FAIL over_sticky c=%0d: got %b expected 1", c, o_credit_error);
         end
      end
      total++;
      if (o_valid !== 1'b1 || o_flit !== 64'hC3 || o_vc !== 2'b10) begin
         bad++; $display("FAIL over_last_link: got %b/%h/%b expected 1/c3/10", o_valid, o_flit, o_vc);
      end
      #1;
      rst     = 1'b1;
      i_valid = 2'b11;
      #1;
      total++;
      if (o_valid !== 1'b0 || o_credit_error !== 1'b0 || o_ready !== 2'b00) begin
         bad++; $display("FAIL midrst: got valid=%b err=%b ready=%b expected 0/0/00",
                         o_valid, o_credit_error, o_ready);
      end
      total++;
      if (o_credit_available !== 2'b11) begin
         bad++; $display("FAIL midrst_avail: got %b expected 11", o_credit_available);
      end
      tick();
      rst     = 1'b0;
      i_valid = 2'b00;
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_starved_recovery();
      test_round_robin();
      test_simultaneous();
      test_over_return();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
